spi_regfile_periph: RTL and testbench

- Parameterised successor to the team's fixed 5×8-bit SPI write-only register block.
- SPI mode-0 peripheral that owns a bank of NUM_REGS registers, each DATA_W bits wide, and supports both write and read-back (CIPO).
- Drives the flattened register bus into the PWM and output-enable logic.
- Emits a one-cycle strobe per register on each committed write, and flags malformed frames.

---
 rtl/spi_regfile_periph.sv | 243 ++++++++++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral owning NUM_REGS x DATA_W registers with write, read-back and strobes.
// Optional SPI_REGFILE_AUTOINC_EN: multi-word frames with auto-incrementing, wrapping address.

module spi_reg_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q,
  output logic              strobe
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= we;
      if (we) q <= din;
    end
  end
endmodule

module spi_regfile_periph #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int HDR_W   = 1 + ADDR_W;
  localparam int SH_W    = (DATA_W > HDR_W) ? DATA_W : HDR_W;
  localparam int CW      = $clog2(FRAME_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd3;
`ifndef SPI_REGFILE_AUTOINC_EN
  localparam logic [2:0] S_OVR   = 3'd4;
`endif

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  function automatic logic [DATA_W-1:0] rd_word(input logic [NUM_REGS*DATA_W-1:0] bank,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (32'(a) == 32'(k)) w = bank[k*DATA_W +: DATA_W];
    return w;
  endfunction

  // Synchronisers clear to 0 so a cs_n held low across reset never looks like a fresh fall.
  logic [SYNC_STAGES-1:0] sclk_sy, cs_sy, copi_sy;
  logic sclk_d, cs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sy <= '0;
      cs_sy   <= '0;
      copi_sy <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk};
      cs_sy   <= {cs_sy[SYNC_STAGES-2:0], cs_n};
      copi_sy <= {copi_sy[SYNC_STAGES-2:0], copi};
      sclk_d  <= sclk_sy[SYNC_STAGES-1];
      cs_d    <= cs_sy[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, copi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_s    = sclk_sy[SYNC_STAGES-1];
  assign cs_s      = cs_sy[SYNC_STAGES-1];
  assign copi_s    = copi_sy[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [SH_W-1:0]   shreg;
  logic [SH_W-1:0]   sh_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q, addr_bad;
  logic [DATA_W-1:0] rd_sh;
  logic              rd_hold;
  wr_req_t           wreq;
  logic              ferr;
`ifdef SPI_REGFILE_AUTOINC_EN
  localparam int WBW = $clog2(DATA_W + 1);
  logic [WBW-1:0]    wbit;
  logic [ADDR_W-1:0] addr_nxt;
  assign addr_nxt = (addr_q == ADDR_W'(NUM_REGS-1)) ? '0 : addr_q + 1'b1;
`else
  logic              ovr;
`endif

  assign sh_nxt = {shreg[SH_W-2:0], copi_s};

  always_comb begin
    wreq = '0;
    ferr = 1'b0;
    if (cs_rise && state != S_IDLE) begin
`ifdef SPI_REGFILE_AUTOINC_EN
      ferr = (state == S_CMD) || (wbit != '0) || addr_bad;
`else
      ferr      = (cnt != CW'(FRAME_W)) || ovr || addr_bad;
      wreq.vld  = rw_q && !ferr;
      wreq.addr = addr_q;
      wreq.data = shreg[DATA_W-1:0];
`endif
    end
`ifdef SPI_REGFILE_AUTOINC_EN
    else if (sclk_rise && !cs_fall && state == S_WDATA &&
             wbit == WBW'(DATA_W-1) && !addr_bad) begin
      wreq.vld  = 1'b1;
      wreq.addr = addr_q;
      wreq.data = sh_nxt[DATA_W-1:0];
    end
`endif
  end

  // cs_n edges take priority over a coincident sclk edge, which is then dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      addr_bad  <= 1'b0;
      rd_sh     <= '0;
      rd_hold   <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_REGFILE_AUTOINC_EN
      wbit      <= '0;
`else
      ovr       <= 1'b0;
`endif
    end else begin
      frame_err <= ferr;
      if (cs_rise) begin
        state <= S_IDLE;
      end else if (cs_fall) begin
        state    <= S_CMD;
        cnt      <= '0;
        shreg    <= '0;
        rw_q     <= 1'b0;
        addr_bad <= 1'b0;
        rd_hold  <= 1'b0;
`ifdef SPI_REGFILE_AUTOINC_EN
        wbit     <= '0;
`else
        ovr      <= 1'b0;
`endif
      end else if (sclk_rise) begin
        case (state)
          S_CMD: begin
            shreg <= sh_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(HDR_W-1)) begin
              rw_q     <= sh_nxt[ADDR_W];
              addr_q   <= sh_nxt[ADDR_W-1:0];
              addr_bad <= !addr_valid(sh_nxt[ADDR_W-1:0]);
              state    <= sh_nxt[ADDR_W] ? S_WDATA : S_RDATA;
              if (!sh_nxt[ADDR_W]) begin
                rd_sh   <= rd_word(regs_out, sh_nxt[ADDR_W-1:0]);
                rd_hold <= 1'b1;
              end
            end
          end
`ifdef SPI_REGFILE_AUTOINC_EN
          S_WDATA, S_RDATA: begin
            shreg <= sh_nxt;
            if (wbit == WBW'(DATA_W-1)) begin
              wbit   <= '0;
              addr_q <= addr_nxt;
              if (state == S_RDATA) begin
                rd_sh   <= addr_bad ? '0 : rd_word(regs_out, addr_nxt);
                rd_hold <= 1'b1;
              end
            end else begin
              wbit <= wbit + 1'b1;
            end
          end
`else
          S_WDATA, S_RDATA: begin
            shreg <= sh_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(FRAME_W-1)) state <= S_OVR;
          end
          S_OVR: ovr <= 1'b1;
`endif
          default: ;
        endcase
      end else if (sclk_fall && state == S_RDATA) begin
        // The fall right after a load keeps the MSB up for the controller's next rise.
        if (rd_hold) rd_hold <= 1'b0;
        else         rd_sh   <= rd_sh << 1;
      end
    end
  end

  assign cipo_oe = (state == S_RDATA);
  assign cipo    = cipo_oe & rd_sh[DATA_W-1];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    spi_reg_slot #(.DATA_W(DATA_W)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .we     (wreq.vld && (wreq.addr == ADDR_W'(k))),
      .din    (wreq.data),
      .q      (regs_out[k*DATA_W +: DATA_W]),
      .strobe (wr_strobe[k])
    );
  end

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: directed SPI frames against a register-bank model.
module tb_spi_regfile_periph;
  localparam int ADDR_W = 7, DATA_W = 8, NUM_REGS = 5, SYNC_STAGES = 2;
  localparam int HDR_W = 1 + ADDR_W, FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int HP = 8;
`ifdef SPI_REGFILE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, copi = 1'b0;
  logic cipo, cipo_oe, frame_err;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [NUM_REGS-1:0] wr_strobe;

  spi_regfile_periph #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
                       .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .copi(copi), .cipo(cipo),
    .cipo_oe(cipo_oe), .regs_out(regs_out), .wr_strobe(wr_strobe), .frame_err(frame_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [DATA_W-1:0] exp_regs [NUM_REGS];
  int exp_wr [NUM_REGS];
  int obs_wr [NUM_REGS];
  int exp_err = 0, obs_err = 0, e0 = 0;
  bit armed = 1'b0, settle = 1'b1;
  int rd_phase = 0;  // 0: bus must be off, 1: must be driving, 2: transition
  logic [NUM_REGS-1:0] prev_strobe = '0, last_strobe = '0;
  logic prev_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] exp_bank();
    logic [NUM_REGS*DATA_W-1:0] b;
    b = '0;
    for (int k = 0; k < NUM_REGS; k++) b[k*DATA_W +: DATA_W] = exp_regs[k];
    return b;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      if (!settle) chk("regs_out", regs_out, exp_bank());
      chk("strobe_one_clk", wr_strobe & prev_strobe, 0);
      chk("frame_err_one_clk", frame_err & prev_err, 0);
      if (rd_phase == 0) begin
        chk("cipo_oe_off", cipo_oe, 0);
        chk("cipo_off", cipo, 0);
      end else if (rd_phase == 1) begin
        chk("cipo_oe_on", cipo_oe, 1);
      end
      for (int k = 0; k < NUM_REGS; k++) if (wr_strobe[k]) obs_wr[k]++;
      if (|wr_strobe) last_strobe = wr_strobe;
      if (frame_err) obs_err++;
      prev_strobe = wr_strobe;
      prev_err    = frame_err;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input int nbits, input int flen, input logic [31:0] frame,
                          input bit chk_rd, input logic [DATA_W-1:0] rd_exp);
    @(negedge clk); cs_n = 1'b0;
    wclk(HP);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < flen) ? frame[flen-1-i] : 1'b1;
      wclk(HP);
      if (chk_rd && i >= HDR_W && i < FRAME_W)
        chk($sformatf("cipo_bit%0d", i - HDR_W), cipo, rd_exp[DATA_W-1-(i-HDR_W)]);
      sclk = 1'b1;
      if (chk_rd && (i == HDR_W-1 || i == FRAME_W-1)) rd_phase = 2;
      wclk(HP);
      if (chk_rd && i == HDR_W-1) rd_phase = 1;
      if (chk_rd && i == FRAME_W-1) rd_phase = AUTOINC ? 2 : 0;
      sclk = 1'b0;
    end
    wclk(HP);
  endtask

  task automatic check_counts(input string tag);
    for (int k = 0; k < NUM_REGS; k++)
      chk($sformatf("%s_wr_cnt%0d", tag, k), obs_wr[k], exp_wr[k]);
    chk($sformatf("%s_err_cnt", tag), obs_err, exp_err);
  endtask

  // Model: a frame commits only if it is exactly FRAME_W bits, a write, and addresses a real register.
  task automatic spi_end(input int nbits, input logic [15:0] frame);
    int a;
    @(negedge clk); cs_n = 1'b1; settle = 1'b1;
    wclk(SYNC_STAGES + 3);
    a = int'(frame[14:8]);
    if (nbits != FRAME_W || a >= NUM_REGS) exp_err++;
    else if (frame[15]) begin
      exp_regs[a] = frame[7:0];
      exp_wr[a]++;
    end
    settle = 1'b0;
    rd_phase = 0;
    wclk(4);
    check_counts("frame");
  endtask

  initial begin
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = '0;
    rst = 1'b1;
    wclk(3);
    armed = 1'b1;
    chk("rst_regs", regs_out, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_frame_err", frame_err, 0);
    settle = 1'b0;
    rst = 1'b0;
    wclk(6);

    // write 0xA5 to reg 3
    spi_bits(16, 16, 32'h83A5, 1'b0, '0);
    spi_end(16, 16'h83A5);
    chk("wr3_bank", regs_out, 40'h00_A5_00_00_00);
    chk("wr3_slice", regs_out[31:24], 8'hA5);
    chk("wr3_strobe", last_strobe, 5'b01000);

    // read it back
    chk("model_reg3", exp_regs[3], 8'hA5);
    e0 = obs_err;
    spi_bits(16, 16, 32'h0300, 1'b1, exp_regs[3]);
    spi_end(16, 16'h0300);
    chk("rd3_no_err", obs_err - e0, 0);

    // short frame
    e0 = obs_err;
    spi_bits(15, 16, 32'h80FF, 1'b0, '0);
    spi_end(15, 16'h80FF);
    chk("short_err", obs_err - e0, 1);
    chk("short_bank", regs_out, 40'h00_A5_00_00_00);

`ifndef SPI_REGFILE_AUTOINC_EN
    // long frame
    e0 = obs_err;
    spi_bits(17, 16, 32'h80FF, 1'b0, '0);
    spi_end(17, 16'h80FF);
    chk("long_err", obs_err - e0, 1);
    chk("long_bank", regs_out, 40'h00_A5_00_00_00);
`endif

    // address one past the bank
    e0 = obs_err;
    spi_bits(16, 16, 32'h8511, 1'b0, '0);
    spi_end(16, 16'h8511);
    chk("addr5_err", obs_err - e0, 1);
    chk("addr5_strobe", last_strobe, 5'b01000);

    // edge registers
    spi_bits(16, 16, 32'h845A, 1'b0, '0);
    spi_end(16, 16'h845A);
    chk("wr4_strobe", last_strobe, 5'b10000);
    spi_bits(16, 16, 32'h8007, 1'b0, '0);
    spi_end(16, 16'h8007);
    chk("edge_bank", regs_out, 40'h5A_A5_00_00_07);
    spi_bits(16, 16, 32'h0400, 1'b1, exp_regs[4]);
    spi_end(16, 16'h0400);

    // read of a missing register returns zeros and flags the frame
    e0 = obs_err;
    spi_bits(16, 16, 32'h0600, 1'b1, 8'h00);
    spi_end(16, 16'h0600);
    chk("rd6_err", obs_err - e0, 1);

    // cs_n pulse with no clocks
    e0 = obs_err;
    spi_bits(0, 16, 32'h0000, 1'b0, '0);
    spi_end(0, 16'h0000);
    chk("empty_err", obs_err - e0, 1);

    // reset in the middle of a write to reg 1
    e0 = obs_err;
    spi_bits(9, 16, 32'h813C, 1'b0, '0);
    @(negedge clk); rst = 1'b1; settle = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = '0;
    wclk(2);
    settle = 1'b0;
    wclk(3);
    chk("midrst_regs", regs_out, 0);
    chk("midrst_strobe", wr_strobe, 0);
    rst = 1'b0;
    wclk(3);
    cs_n = 1'b1;
    wclk(10);
    chk("midrst_no_err", obs_err - e0, 0);
    check_counts("midrst");
    spi_bits(16, 16, 32'h813C, 1'b0, '0);
    spi_end(16, 16'h813C);
    chk("postrst_bank", regs_out, 40'h00_00_00_3C_00);

`ifdef SPI_REGFILE_AUTOINC_EN
    // two words from reg 4, wrapping to reg 0
    e0 = obs_err;
    settle = 1'b1;
    spi_bits(24, 24, 32'h0084_1234, 1'b0, '0);
    @(negedge clk); cs_n = 1'b1;
    wclk(8);
    exp_regs[4] = 8'h12; exp_regs[0] = 8'h34;
    exp_wr[4]++; exp_wr[0]++;
    settle = 1'b0;
    wclk(2);
    chk("ai_reg4", regs_out[39:32], 8'h12);
    chk("ai_reg0", regs_out[7:0], 8'h34);
    chk("ai_no_err", obs_err - e0, 0);
    check_counts("autoinc");
`endif

    wclk(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
